// File: rtl/run_pkg.sv
// Shared types and default constants for the run sequencer.
package run_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HOLD = 2'b01,
    RUN  = 2'b10,
    DONE = 2'b11
  } state_t;

  localparam int RST_CYC_DEF = 2;
  localparam int TIMEOUT_DEF = 4000;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         at_max
);

  assign at_max = (q == {W{1'b1}});

  // Clear wins over count; counting stops once the top value is reached.
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en && !at_max) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/run_sequencer.sv
// Run sequencer: holds the core in reset, launches a run, watches for
// completion or runaway, and reports the outcome to the host.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | core held in reset, waiting for start
// HOLD  | core still in reset for RST_CYC cycles after start
// RUN   | core released; cycles counted, done/watchdog monitored
// DONE  | run ended; core frozen in reset, results held until start
module run_sequencer
  import run_pkg::*;
#(
  parameter int D       = 12,
  parameter int CW      = 16,
  parameter int RST_CYC = RST_CYC_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          core_done,
  input  logic [D-1:0]  prog_ctr,
  output logic          core_reset,
  output logic          core_req,
  output logic          busy,
  output logic          finished,
  output logic          timed_out,
  output logic [CW-1:0] cycle_cnt,
  output logic [D-1:0]  last_pc
);

  if (RST_CYC < 1 || RST_CYC > 15) begin : g_bad_rst_cyc
    $error("run_sequencer: RST_CYC must be in 1..15");
  end
  if (TIMEOUT < 1 || TIMEOUT > (2**CW) - 1) begin : g_bad_timeout
    $error("run_sequencer: TIMEOUT must be in 1..2**CW-1");
  end

  localparam logic [3:0]    HOLD_INIT = 4'(RST_CYC - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT - 1);

  state_t     state, state_nx;
  logic [3:0] hold_q, hold_nx;
  logic       launch;
  logic       cnt_en;
  logic       end_done;
  logic       end_tmo;
  logic       cnt_max;

  // A launch or a reset zeroes the run-cycle count.
  sat_counter #(.W(CW)) u_cycle_cnt (
    .clk    (clk),
    .clr    (reset | launch),
    .en     (cnt_en),
    .q      (cycle_cnt),
    .at_max (cnt_max)
  );

  // Next-state logic; abort outranks core_done, which outranks the watchdog.
  always_comb begin
    state_nx = state;
    hold_nx  = hold_q;
    launch   = 1'b0;
    cnt_en   = 1'b0;
    end_done = 1'b0;
    end_tmo  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx = HOLD;
          hold_nx  = HOLD_INIT;
          launch   = 1'b1;
        end
      end
      HOLD: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (hold_q == 4'd0) begin
          state_nx = RUN;
        end else begin
          hold_nx = hold_q - 4'd1;
        end
      end
      RUN: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (core_done) begin
          state_nx = DONE;
          end_done = 1'b1;
        end else begin
          cnt_en = 1'b1;
          if (cycle_cnt == TMO_LAST) begin
            state_nx = DONE;
            end_tmo  = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register and registered outputs, all derived from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      hold_q     <= 4'd0;
      core_reset <= 1'b1;
      core_req   <= 1'b0;
      busy       <= 1'b0;
      finished   <= 1'b0;
      timed_out  <= 1'b0;
      last_pc    <= '0;
    end else begin
      state      <= state_nx;
      hold_q     <= hold_nx;
      core_reset <= (state_nx != RUN);
      core_req   <= (state == HOLD) && (state_nx == RUN);
      busy       <= (state_nx == HOLD) || (state_nx == RUN);
      if (launch || state_nx == IDLE) begin
        finished  <= 1'b0;
        timed_out <= 1'b0;
      end else begin
        if (end_done) finished  <= 1'b1;
        if (end_tmo)  timed_out <= 1'b1;
      end
      if (end_done || end_tmo) begin
        last_pc <= prog_ctr;
      end
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: cycle model plus directed literal expectations.
module tb_run_sequencer;

  localparam int D       = 12;
  localparam int CW      = 16;
  localparam int RST_CYC = 2;
  localparam int TIMEOUT = 50;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          core_done = 1'b0;
  logic [D-1:0]  prog_ctr = '0;
  logic          core_reset, core_req, busy, finished, timed_out;
  logic [CW-1:0] cycle_cnt;
  logic [D-1:0]  last_pc;

  int n_checks = 0;
  int n_pass   = 0;

  run_sequencer #(.D(D), .CW(CW), .RST_CYC(RST_CYC), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .core_done  (core_done),
    .prog_ctr   (prog_ctr),
    .core_reset (core_reset),
    .core_req   (core_req),
    .busy       (busy),
    .finished   (finished),
    .timed_out  (timed_out),
    .cycle_cnt  (cycle_cnt),
    .last_pc    (last_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h want=%0h", name, got, exp);
    else n_pass++;
  endtask

  // Behavioural model: phases of a run, tracked with plain counters.
  localparam int P_IDLE = 0, P_HOLD = 1, P_RUN = 2, P_DONE = 3;
  int            ph = P_IDLE;
  int            hold_left = 0;
  bit            m_valid = 0;
  bit            m_req = 0, m_fin = 0, m_tmo = 0;
  logic [CW-1:0] m_cnt = '0;
  logic [D-1:0]  m_pc = '0;

  always @(posedge clk) begin
    m_req = 0;
    if (reset) begin
      ph = P_IDLE; m_cnt = '0; m_fin = 0; m_tmo = 0; m_pc = '0; m_valid = 1;
    end else begin
      case (ph)
        P_IDLE, P_DONE: if (start) begin
          ph = P_HOLD; hold_left = RST_CYC; m_cnt = '0; m_fin = 0; m_tmo = 0;
        end
        P_HOLD: if (abort) ph = P_IDLE;
                else begin
                  hold_left--;
                  if (hold_left == 0) begin ph = P_RUN; m_req = 1; end
                end
        P_RUN: if (abort) begin
                 ph = P_IDLE; m_fin = 0; m_tmo = 0;
               end else if (core_done) begin
                 ph = P_DONE; m_fin = 1; m_pc = prog_ctr;
               end else begin
                 if (m_cnt != '1) m_cnt++;
                 if (int'(m_cnt) == TIMEOUT) begin ph = P_DONE; m_tmo = 1; m_pc = prog_ctr; end
               end
        default: ph = P_IDLE;
      endcase
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("core_reset", 32'(core_reset), 32'(ph != P_RUN));
      chk("core_req",   32'(core_req),   32'(m_req));
      chk("busy",       32'(busy),       32'(ph == P_HOLD || ph == P_RUN));
      chk("finished",   32'(finished),   32'(m_fin));
      chk("timed_out",  32'(timed_out),  32'(m_tmo));
      chk("cycle_cnt",  32'(cycle_cnt),  32'(m_cnt));
      chk("last_pc",    32'(last_pc),    32'(m_pc));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch_to_run();
    start = 1'b1; step(); start = 1'b0;   // HOLD 1
    step();                               // HOLD 2
    step();                               // RUN 1
  endtask

  initial begin
    int n_run;
    // Reset values
    step(); step();
    chk("rst core_reset", 32'(core_reset), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst cycle_cnt", 32'(cycle_cnt), 32'd0);
    chk("rst last_pc", 32'(last_pc), 32'd0);
    reset = 1'b0;
    step(); step(); step();

    // Launch latency and request pulse
    start = 1'b1; step(); start = 1'b0;
    chk("hold busy", 32'(busy), 32'd1);
    chk("hold core_reset", 32'(core_reset), 32'd1);
    chk("hold core_req", 32'(core_req), 32'd0);
    step();
    chk("hold2 core_reset", 32'(core_reset), 32'd1);
    step();
    chk("run1 core_reset", 32'(core_reset), 32'd0);
    chk("run1 core_req", 32'(core_req), 32'd1);
    prog_ctr = 12'h0A5;
    step();
    chk("run2 core_req", 32'(core_req), 32'd0);
    repeat (36) step();
    chk("pre-done cnt", 32'(cycle_cnt), 32'd37);
    core_done = 1'b1; step(); core_done = 1'b0;
    chk("done finished", 32'(finished), 32'd1);
    chk("done timed_out", 32'(timed_out), 32'd0);
    chk("done cycle_cnt", 32'(cycle_cnt), 32'd37);
    chk("done last_pc", 32'(last_pc), 32'h0A5);
    chk("done core_reset", 32'(core_reset), 32'd1);
    chk("done busy", 32'(busy), 32'd0);
    // abort is ignored in DONE
    abort = 1'b1; step(); abort = 1'b0;
    chk("done abort finished", 32'(finished), 32'd1);

    // Watchdog with core_done never rising
    prog_ctr = 12'h123;
    launch_to_run();
    n_run = 1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (core_reset) break;
      n_run++;
    end
    chk("tmo run cycles", 32'(n_run), 32'd50);
    chk("tmo timed_out", 32'(timed_out), 32'd1);
    chk("tmo finished", 32'(finished), 32'd0);
    chk("tmo cycle_cnt", 32'(cycle_cnt), 32'd50);
    chk("tmo last_pc", 32'(last_pc), 32'h123);

    // core_done beats the watchdog at cycle_cnt==TIMEOUT-1
    launch_to_run();
    repeat (49) step();
    chk("edge cnt", 32'(cycle_cnt), 32'd49);
    core_done = 1'b1; step(); core_done = 1'b0;
    chk("edge finished", 32'(finished), 32'd1);
    chk("edge timed_out", 32'(timed_out), 32'd0);
    chk("edge cycle_cnt", 32'(cycle_cnt), 32'd49);

    // Abort in RUN keeps the count; a new start clears it
    launch_to_run();
    repeat (10) step();
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort finished", 32'(finished), 32'd0);
    chk("abort cycle_cnt", 32'(cycle_cnt), 32'd10);
    chk("abort core_reset", 32'(core_reset), 32'd1);
    start = 1'b1; step(); start = 1'b0;
    chk("restart cycle_cnt", 32'(cycle_cnt), 32'd0);
    chk("restart busy", 32'(busy), 32'd1);
    // Abort in HOLD
    abort = 1'b1; step(); abort = 1'b0;
    chk("hold abort busy", 32'(busy), 32'd0);
    step();
    chk("hold abort stays idle", 32'(core_reset), 32'd1);

    // Reset in the middle of a run
    prog_ctr = 12'h3C3;
    launch_to_run();
    repeat (3) step();
    core_done = 1'b1; step(); core_done = 1'b0;   // leaves last_pc nonzero
    launch_to_run();
    repeat (19) step();
    reset = 1'b1; step(); reset = 1'b0;
    chk("midrst core_reset", 32'(core_reset), 32'd1);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst finished", 32'(finished), 32'd0);
    chk("midrst cycle_cnt", 32'(cycle_cnt), 32'd0);
    chk("midrst last_pc", 32'(last_pc), 32'd0);

    // start held high: relaunch straight out of DONE; done in first RUN cycle
    start = 1'b1;
    step(); step(); step();
    chk("held run1", 32'(core_req), 32'd1);
    core_done = 1'b1; step(); core_done = 1'b0;
    chk("held done finished", 32'(finished), 32'd1);
    chk("held done cnt", 32'(cycle_cnt), 32'd0);
    chk("held done busy", 32'(busy), 32'd0);
    step();
    chk("held relaunch busy", 32'(busy), 32'd1);
    chk("held relaunch finished", 32'(finished), 32'd0);
    start = 1'b0;
    step(); step(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit got=expired want=finished");
    $fatal(1, "time limit");
  end

endmodule
